// File: rtl/alu_operand_sequencer.sv
`timescale 1ns/1ps
// alu_operand_sequencer: debounced push-button entry of operands a, b and an opcode
// for the demo ALU, with optional timed auto-stepping of the opcode while in RUN.
module alu_operand_sequencer #(
   parameter int WIDTH           = 3,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int STEP_CYCLES     = 50_000_000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             btn_next,
   input  logic [WIDTH-1:0] sw,
   input  logic             auto_en,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [3:0]       op,
   output logic             op_valid,
   output logic [1:0]       entry_state
);

   localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

   typedef enum logic [1:0] {
      ENTER_A  = 2'd0,
      ENTER_B  = 2'd1,
      ENTER_OP = 2'd2,
      RUN      = 2'd3
   } state_t;

   // Two-flop synchronizers for every raw board input
   logic             btn_m, btn_s;
   logic             auto_m, auto_s;
   logic [WIDTH-1:0] sw_m, sw_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_m  <= 1'b0;
         btn_s  <= 1'b0;
         auto_m <= 1'b0;
         auto_s <= 1'b0;
         sw_m   <= '0;
         sw_s   <= '0;
      end else begin
         btn_m  <= btn_next;
         btn_s  <= btn_m;
         auto_m <= auto_en;
         auto_s <= auto_m;
         sw_m   <= sw;
         sw_s   <= sw_m;
      end
   end

   // Debounce: accept a new button level only after DEBOUNCE_CYCLES disagreeing samples
   logic [DEB_W-1:0] deb_cnt;
   logic             btn_deb, btn_deb_d, press_evt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_cnt <= '0;
         btn_deb <= 1'b0;
      end else if (btn_s != btn_deb) begin
         if (deb_cnt == DEB_LAST) begin
            btn_deb <= btn_s;
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
         end
      end else begin
         deb_cnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_deb_d <= 1'b0;
         press_evt <= 1'b0;
      end else begin
         btn_deb_d <= btn_deb;
         press_evt <= btn_deb & ~btn_deb_d;
      end
   end

   // op_valid is a one-cycle strobe with no ready: the consumer must take a/b/op in the
   // cycle op_valid is high; the values then stay put until the next strobe or press.
   state_t            state, state_nx;
   logic [WIDTH-1:0]  a_nx, b_nx;
   logic [3:0]        op_nx;
   logic              op_valid_nx;
   logic [STEP_W-1:0] step_cnt, step_nx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ENTER_A;
         a        <= '0;
         b        <= '0;
         op       <= 4'd0;
         op_valid <= 1'b0;
         step_cnt <= '0;
      end else begin
         state    <= state_nx;
         a        <= a_nx;
         b        <= b_nx;
         op       <= op_nx;
         op_valid <= op_valid_nx;
         step_cnt <= step_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      a_nx        = a;
      b_nx        = b;
      op_nx       = op;
      op_valid_nx = 1'b0;
      step_nx     = step_cnt;
      case (state)
         ENTER_A: begin
            if (press_evt) begin
               a_nx     = sw_s;
               state_nx = ENTER_B;
            end
         end
         ENTER_B: begin
            if (press_evt) begin
               b_nx     = sw_s;
               state_nx = ENTER_OP;
            end
         end
         ENTER_OP: begin
            if (press_evt) begin
               op_nx       = {1'b0, sw_s[2:0]};
               op_valid_nx = 1'b1;
               step_nx     = '0;
               state_nx    = RUN;
            end
         end
         RUN: begin
            // A press wins over a coincident auto-step
            if (press_evt) begin
               step_nx  = '0;
               state_nx = ENTER_A;
            end else if (auto_s) begin
               if (step_cnt == STEP_LAST) begin
                  op_nx       = {1'b0, op[2:0] + 3'd1};
                  op_valid_nx = 1'b1;
                  step_nx     = '0;
               end else begin
                  step_nx = step_cnt + STEP_W'(1);
               end
            end else begin
               step_nx = '0;
            end
         end
         default: state_nx = ENTER_A;
      endcase
   end

   assign entry_state = state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for alu_operand_sequencer: directed test-plan scenarios with literal
// expectations plus randomized button/switch/auto traffic against a behavioural model.
module tb_alu_operand_sequencer;

   localparam int W    = 3;
   localparam int DEB  = 4;
   localparam int STEP = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         btn_next = 1'b0;
   logic         auto_en = 1'b0;
   logic [W-1:0] sw = '0;
   logic [W-1:0] a, b;
   logic [3:0]   op;
   logic         op_valid;
   logic [1:0]   entry_state;

   int errors = 0;
   int checks = 0;
   int pulse_cnt = 0;

   // behavioural model state
   bit         m_btn_m, m_btn_s, m_auto_m, m_auto_s;
   bit [2:0]   m_sw_m, m_sw_s;
   bit         m_deb, m_deb_d, m_press, m_valid;
   bit [2:0]   m_a, m_b, m_op;
   int         m_phase, m_step;
   bit         hist[$];
   logic [8:0] exp_q[$];

   alu_operand_sequencer #(
      .WIDTH(W), .DEBOUNCE_CYCLES(DEB), .STEP_CYCLES(STEP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_next(btn_next), .sw(sw), .auto_en(auto_en),
      .a(a), .b(b), .op(op), .op_valid(op_valid), .entry_state(entry_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_btn_m = 0; m_btn_s = 0; m_auto_m = 0; m_auto_s = 0;
      m_sw_m = 0; m_sw_s = 0;
      m_deb = 0; m_deb_d = 0; m_press = 0; m_valid = 0;
      m_a = 0; m_b = 0; m_op = 0; m_phase = 0; m_step = 0;
      hist.delete();
      exp_q.delete();
   endtask

   task automatic model_step();
      bit p;
      bit flip;
      p = m_press;
      m_valid = 1'b0;
      case (m_phase)
         0: if (p) begin m_a = m_sw_s; m_phase = 1; end
         1: if (p) begin m_b = m_sw_s; m_phase = 2; end
         2: if (p) begin m_op = m_sw_s; m_valid = 1'b1; m_phase = 3; m_step = 0; end
         default: begin
            if (p) begin
               m_phase = 0;
               m_step = 0;
            end else if (m_auto_s) begin
               m_step++;
               if (m_step == STEP) begin
                  m_op = 3'((int'(m_op) + 1) % 8);
                  m_valid = 1'b1;
                  m_step = 0;
               end
            end else begin
               m_step = 0;
            end
         end
      endcase
      if (m_valid) exp_q.push_back({m_a, m_b, m_op});
      // rising edge of the accepted level becomes a one-cycle press
      m_press = m_deb & ~m_deb_d;
      m_deb_d = m_deb;
      // level accepted once the last DEB synced samples all disagree with it
      hist.push_back(m_btn_s);
      if (hist.size() > DEB) void'(hist.pop_front());
      if (hist.size() == DEB) begin
         flip = 1'b1;
         foreach (hist[i]) if (hist[i] == m_deb) flip = 1'b0;
         if (flip) m_deb = ~m_deb;
      end
      m_btn_s = m_btn_m;  m_btn_m = btn_next;
      m_auto_s = m_auto_m; m_auto_m = auto_en;
      m_sw_s = m_sw_m;    m_sw_m = sw;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_step();
      end
   end

   // scoreboard: every cycle against the model, issued ops against exp_q
   initial begin
      logic [8:0] t;
      forever begin
         @(negedge clk);
         chk("a", int'(a), int'(m_a));
         chk("b", int'(b), int'(m_b));
         chk("op", int'(op), int'(m_op));
         chk("op_valid", int'(op_valid), int'(m_valid));
         chk("entry_state", int'(entry_state), m_phase);
         if (op_valid) begin
            pulse_cnt++;
            chk("issue_queue_nonempty", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               t = exp_q.pop_front();
               chk("issued_op", int'({a, b, op[2:0]}), int'(t));
            end
         end
      end
   end

   // driver tasks
   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      cycles(3);
      rst_n = 1'b1;
   endtask

   task automatic press(input logic [W-1:0] v);
      sw = v;
      cycles(2);
      btn_next = 1'b1;
      cycles(12);
      btn_next = 1'b0;
      cycles(12);
   endtask

   task automatic enter_run(input logic [W-1:0] va, input logic [W-1:0] vb, input logic [W-1:0] vo);
      do_reset();
      press(va);
      press(vb);
      press(vo);
   endtask

   initial begin
      int p0;
      // reset state
      cycles(3);
      chk("reset_a", int'(a), 0);
      chk("reset_b", int'(b), 0);
      chk("reset_op", int'(op), 0);
      chk("reset_op_valid", int'(op_valid), 0);
      chk("reset_state", int'(entry_state), 0);
      rst_n = 1'b1;
      cycles(2);

      // entry sequence
      p0 = pulse_cnt;
      press(3'd5);
      chk("entry_state_after_a", int'(entry_state), 1);
      chk("entry_a", int'(a), 5);
      press(3'd1);
      chk("entry_state_after_b", int'(entry_state), 2);
      chk("entry_b", int'(b), 1);
      press(3'd0);
      chk("entry_state_after_op", int'(entry_state), 3);
      chk("entry_op", int'(op), 0);
      chk("entry_pulses", pulse_cnt - p0, 1);

      // auto-step wrap 6 -> 7 -> 0
      enter_run(3'd2, 3'd3, 3'd6);
      p0 = pulse_cnt;
      auto_en = 1'b1;
      cycles(9);
      chk("auto_before_step_op", int'(op), 6);
      cycles(1);
      chk("auto_step1_op", int'(op), 7);
      chk("auto_step1_valid", int'(op_valid), 1);
      cycles(1);
      chk("auto_step1_valid_drop", int'(op_valid), 0);
      cycles(7);
      chk("auto_wrap_op", int'(op), 0);
      chk("auto_wrap_valid", int'(op_valid), 1);
      auto_en = 1'b0;
      cycles(30);
      chk("auto_frozen_op", int'(op), 0);
      chk("auto_pulses", pulse_cnt - p0, 2);

      // press coinciding with the auto-step edge
      enter_run(3'd4, 3'd7, 3'd2);
      p0 = pulse_cnt;
      auto_en = 1'b1;
      cycles(2);
      btn_next = 1'b1;
      cycles(8);
      chk("collide_state", int'(entry_state), 0);
      chk("collide_op", int'(op), 2);
      chk("collide_valid", int'(op_valid), 0);
      cycles(1);
      chk("collide_valid_next", int'(op_valid), 0);
      auto_en = 1'b0;
      btn_next = 1'b0;
      cycles(12);
      chk("collide_pulses", pulse_cnt - p0, 0);

      // bounce rejection
      sw = 3'd3;
      for (int i = 0; i < 5; i++) begin
         btn_next = 1'b1; cycles(3);
         btn_next = 1'b0; cycles(2);
      end
      chk("bounce_ignored", int'(entry_state), 0);
      btn_next = 1'b1;
      cycles(7);
      chk("bounce_press_not_yet", int'(entry_state), 0);
      cycles(1);
      chk("bounce_press_state", int'(entry_state), 1);
      chk("bounce_press_a", int'(a), 3);
      cycles(12);
      for (int i = 0; i < 5; i++) begin
         btn_next = 1'b0; cycles(3);
         btn_next = 1'b1; cycles(2);
      end
      btn_next = 1'b0;
      cycles(20);
      chk("release_no_event", int'(entry_state), 1);

      // button held through reset release
      @(negedge clk);
      btn_next = 1'b1;
      sw = 3'd6;
      rst_n = 1'b0;
      cycles(3);
      rst_n = 1'b1;
      cycles(7);
      chk("held_reset_not_yet", int'(entry_state), 0);
      cycles(1);
      chk("held_reset_state", int'(entry_state), 1);
      chk("held_reset_a", int'(a), 6);
      cycles(20);
      chk("held_reset_single", int'(entry_state), 1);
      btn_next = 1'b0;
      cycles(12);

      // asynchronous reset mid-RUN
      enter_run(3'd5, 3'd1, 3'd3);
      auto_en = 1'b1;
      cycles(5);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_a", int'(a), 0);
      chk("async_rst_b", int'(b), 0);
      chk("async_rst_op", int'(op), 0);
      chk("async_rst_valid", int'(op_valid), 0);
      chk("async_rst_state", int'(entry_state), 0);
      cycles(3);
      rst_n = 1'b1;
      p0 = pulse_cnt;
      cycles(30);
      chk("post_rst_pulses", pulse_cnt - p0, 0);
      chk("post_rst_state", int'(entry_state), 0);
      auto_en = 1'b0;

      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         if (i == 150) do_reset();
         btn_next = 1'($urandom_range(0, 1));
         sw = W'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) auto_en = ~auto_en;
         cycles($urandom_range(1, 12));
      end
      btn_next = 1'b0;
      auto_en = 1'b0;
      cycles(20);
      chk("issue_queue_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
- Upstream feeder for the 3-bit demo ALU. Turns raw board inputs (one push-button, 3 slide switches, one auto-mode switch) into registered operands a, b and a 4-bit opcode, with a one-cycle op_valid strobe.
- Operands and opcode are entered one per button press.
- In RUN, the opcode can auto-step through the op set at a fixed rate so the ALU/LED stage cycles its operations.

Parameters:
- WIDTH, 3, operand width (a, b, sw).
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles needed to accept a level change on btn_next (20 ms at 50 MHz).
- STEP_CYCLES, 50_000_000, RUN-mode auto-step period in clk cycles.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- btn_next  in  1  raw push-button, active-high, asynchronous, bouncy.
- sw  in  WIDTH  raw slide switches, asynchronous.
- auto_en  in  1  raw auto-step enable switch, asynchronous.
- a  out  WIDTH  registered operand A.
- b  out  WIDTH  registered operand B.
- op  out  4  registered ALU opcode; op[3] is always 0.
- op_valid  out  1  one-cycle strobe; high in the cycle op/a/b first show a newly issued operation.
- entry_state  out  2  current FSM state encoding.

Behaviour:
- One clock domain. rst_n is asynchronous assert, active-low.
- Reset values:
  - a=0, b=0, op=0, op_valid=0, entry_state=0 (ENTER_A).
  - All synchronizer flops, counters and the debounced level are 0.
- Synchronizers:
  - btn_next, auto_en and each sw bit pass through a 2-flop synchronizer; the outputs are btn_s, auto_s, sw_s.
  - All logic below uses only these synced signals.
- Debounce:
  - deb_cnt increments every cycle btn_s != btn_deb.
  - deb_cnt clears to 0 in any cycle btn_s == btn_deb.
  - When a mismatch cycle sees deb_cnt == DEBOUNCE_CYCLES-1: btn_deb <= btn_s and deb_cnt <= 0.
- Press event:
  - press_evt is registered: btn_deb & ~btn_deb_d, one cycle wide.
  - Falling edges generate no event.
  - Latency: a raw rise held stable yields press_evt high for exactly one cycle, after the (DEBOUNCE_CYCLES+3)th rising clk edge counting the first edge that samples btn_next high.
  - Any high pulse shorter than DEBOUNCE_CYCLES synced cycles is ignored.
- FSM states: ENTER_A=0, ENTER_B=1, ENTER_OP=2, RUN=3. Transitions fire only on press_evt, except auto-step.
  - ENTER_A: on press_evt, a <= sw_s; go to ENTER_B.
  - ENTER_B: on press_evt, b <= sw_s; go to ENTER_OP.
  - ENTER_OP: on press_evt, op <= {1'b0, sw_s}; op_valid <= 1 for one cycle; go to RUN; step_cnt <= 0.
  - RUN, press_evt: go to ENTER_A; step_cnt <= 0. a, b and op retain their values; no op_valid.
  - RUN, auto_s=1:
    - step_cnt increments every cycle.
    - At step_cnt == STEP_CYCLES-1: op[2:0] <= op[2:0]+1 (wraps 7->0, op[3] stays 0), op_valid <= 1, step_cnt <= 0.
  - RUN, auto_s=0: step_cnt is held at 0 and op is static. Re-asserting auto_en restarts a full STEP_CYCLES period.
- Priority: press_evt beats auto-step in the same cycle. The state leaves RUN, op is not incremented, and op_valid stays 0.
- op_valid is only ever set by ENTER_OP capture or an auto-step; it is never high two cycles in a row, except when STEP_CYCLES=1.
- Each register captures sw_s as sampled in the press_evt cycle.
- Outputs change only on clk edges or asynchronously to reset values when rst_n falls.
- A reset asserted mid-entry or mid-step discards all partial state.
- A button held through rst_n deassertion produces exactly one press_evt after the debounce period, because btn_deb resets to 0.

Test Plan (DEBOUNCE_CYCLES=4, STEP_CYCLES=8):
1. Reset mid-RUN: a=5, b=1, op=3, auto stepping, drop rst_n between edges -> a, b, op, op_valid and entry_state all 0 immediately without waiting for clk; no op_valid after release.
2. Entry sequence: sw=5 press; sw=1 press; sw=0 press (each held ≥10 cycles) -> a=5, b=1, op=0; op_valid high exactly one cycle after the third press_evt; entry_state reads 0,1,2,3 in turn.
3. Bounce rejection: btn_next high 3 cycles / low 2 cycles, repeated 5 times, then stable high 20 cycles -> exactly one press_evt, issued 7 edges (DEBOUNCE_CYCLES+3) after the stable high begins; release with bounce -> no event.
4. Auto-step wrap: in RUN with op=6, set auto_en=1 -> after sync, op=7 with an op_valid pulse 8 cycles later, then op=0 with a pulse 8 cycles after that; clear auto_en -> op frozen, no pulses.
5. Collision: in RUN with auto_en=1, align press_evt with step_cnt==7 -> entry_state=0, op unchanged, op_valid stays 0 in that cycle and the next.
6. Hold across reset: btn_next high during rst_n low, release rst_n -> one press_evt 7 edges after the synchronizer sees the button high; a captures sw; entry_state=1.
